// File: rtl/window_pkg.sv
// Shared types and helpers for the sliding-window generator.
// Optional feature macro used by the top level: WINDOW_STREAM_POS_EN.
package window_pkg;

    localparam int unsigned MAX_IMG_WIDTH  = 4096;
    localparam int unsigned MAX_IMG_HEIGHT = 4096;

    // Counter/address width for a range of n values, never narrower than 1 bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned POS_ROW_W = cnt_width(MAX_IMG_HEIGHT);
    localparam int unsigned POS_COL_W = cnt_width(MAX_IMG_WIDTH);

    typedef struct packed {
        logic [POS_ROW_W-1:0] row;
        logic [POS_COL_W-1:0] col;
    } win_pos_t;

endpackage

// File: rtl/line_buffer_ram.sv
// One image line of pixel storage with read-before-write behaviour:
// the old entry at addr is visible combinationally while the new one
// is written on the clock edge.
module line_buffer_ram
    import window_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [cnt_width(DEPTH)-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Store the incoming pixel; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_stream_gen.sv
// Streaming KxK sliding-window generator for raster-order pixel streams.
// K-1 line buffers feed a KxK register window; a single output stage
// with valid/ready flow control presents only windows fully inside the image.
// Optional macro WINDOW_STREAM_POS_EN adds registered window-centre
// coordinates (out_row/out_col).
module window_stream_gen
    import window_pkg::*;
#(
    parameter int unsigned PIXEL_DEPTH = 8,
    parameter int unsigned IMG_WIDTH   = 64,
    parameter int unsigned IMG_HEIGHT  = 48,
    parameter int unsigned K           = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PIXEL_DEPTH-1:0]         in_pixel,
    input  logic                           in_sof,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [K*K*PIXEL_DEPTH-1:0]     out_window,
`ifdef WINDOW_STREAM_POS_EN
    output logic [cnt_width(IMG_HEIGHT)-1:0] out_row,
    output logic [cnt_width(IMG_WIDTH)-1:0]  out_col,
`endif
    output logic                           out_last
);

    localparam int unsigned COL_W = cnt_width(IMG_WIDTH);
    localparam int unsigned ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_KM1  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(K - 1);

    logic             accept;
    logic [COL_W-1:0] col, col_nxt, eff_col;
    logic [ROW_W-1:0] row, row_nxt, eff_row;

    logic [PIXEL_DEPTH-1:0] lb_rd [K-1];
    logic [PIXEL_DEPTH-1:0] lb_wr [K-1];

    logic [K-1:0][PIXEL_DEPTH-1:0]        new_col;
    logic [K-1:0][K-1:0][PIXEL_DEPTH-1:0] win, win_nxt;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_window = win;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say
    assign eff_col = in_sof ? '0 : col;
    assign eff_row = in_sof ? '0 : row;

    // Raster position of the pixel following the one being accepted
    always_comb begin
        col_nxt = eff_col + 1'b1;
        row_nxt = eff_row;
        if (eff_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
        end
    end

    // Line 0 takes the new pixel; each deeper line takes its predecessor's old entry
    genvar j;
    generate
        for (j = 0; j < K - 1; j++) begin : g_line
            if (j == 0) begin : g_first
                assign lb_wr[j] = in_pixel;
            end else begin : g_chain
                assign lb_wr[j] = lb_rd[j-1];
            end

            line_buffer_ram #(
                .DATA_WIDTH (PIXEL_DEPTH),
                .DEPTH      (IMG_WIDTH)
            ) u_line (
                .clk     (clk),
                .wr_en   (accept),
                .addr    (eff_col),
                .wr_data (lb_wr[j]),
                .rd_data (lb_rd[j])
            );
        end
    endgenerate

    // Incoming window column, oldest line on top, current pixel at the bottom
    always_comb begin
        new_col      = '0;
        new_col[K-1] = in_pixel;
        for (int unsigned r = 0; r < K - 1; r++) begin
            new_col[r] = lb_rd[K-2-r];
        end
    end

    // Window shifted one column toward index 0 with the new column at K-1
    always_comb begin
        win_nxt = win;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
            win_nxt[r][K-1] = new_col[r];
        end
    end

    // Frame position counters advance on every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // Output stage: load on accept, drop valid once consumed, hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            win       <= '0;
        end else if (accept) begin
            out_valid <= (eff_row >= ROW_KM1) && (eff_col >= COL_KM1);
            out_last  <= (eff_row == ROW_LAST) && (eff_col == COL_LAST);
            win       <= win_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WINDOW_STREAM_POS_EN
    localparam logic [COL_W-1:0] COL_HALF = COL_W'(K / 2);
    localparam logic [ROW_W-1:0] ROW_HALF = ROW_W'(K / 2);

    win_pos_t pos;

    assign out_row = ROW_W'(pos.row);
    assign out_col = COL_W'(pos.col);

    // Window centre coordinates, registered alongside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= '0;
        end else if (accept) begin
            pos.row <= POS_ROW_W'(eff_row - ROW_HALF);
            pos.col <= POS_COL_W'(eff_col - COL_HALF);
        end
    end
`endif

endmodule
